// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the dot-RAM write arbiter.
package fb_pkg;

  localparam int unsigned COLS    = 200;
  localparam int unsigned ROWS    = 150;
  localparam int unsigned CELLS   = COLS * ROWS;
  localparam int unsigned AW      = 15;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fb_write_arbiter.sv
// Dot-RAM port arbiter: display reads always win, requester writes and the
// clear-screen sequencer use the cycles the display leaves free.
module fb_write_arbiter
  import fb_pkg::*;
(
  input  logic               pclk,
  input  logic               rstn,
  input  logic               disp_req,
  input  logic [AW-1:0]      disp_addr,
  input  logic               wr_valid,
  input  logic [AW-1:0]      wr_addr,
  input  logic               wr_data,
  output logic               wr_ready,
  input  logic               clr_start,
  input  logic               clr_val,
  output logic               clr_busy,
  output logic               clr_done,
  output logic               err_addr,
  output logic [STALL_W-1:0] stall_cnt,
  output logic               ram_en,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_din
);

  localparam logic [AW-1:0]      CELLS_A   = AW'(CELLS);
  localparam logic [AW-1:0]      LAST_A    = AW'(CELLS - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};

  state_t               state, state_nx;
  logic [AW-1:0]        cnt, cnt_nx;
  logic                 val, val_nx;
  logic                 err_nx;
  logic                 busy_nx, done_nx;
  logic [STALL_W-1:0]   stall_nx;
  logic                 accept;
  logic                 in_range;
  logic                 we_raw;

  // Handshake is gated by rstn so no transfer can complete while in reset.
  always_comb begin
    wr_ready = rstn & (state == IDLE) & ~disp_req & ~clr_start;
    accept   = wr_valid & wr_ready;
    in_range = (wr_addr < CELLS_A);
  end

  // RAM port mux; the display path is pure pass-through.
  always_comb begin
    ram_en   = 1'b0;
    we_raw   = 1'b0;
    ram_addr = '0;
    ram_din  = 1'b0;
    if (disp_req) begin
      ram_en   = 1'b1;
      ram_addr = disp_addr;
    end else if (state == CLEAR) begin
      ram_en   = 1'b1;
      we_raw   = 1'b1;
      ram_addr = cnt;
      ram_din  = val;
    end else if (accept) begin
      ram_en   = 1'b1;
      we_raw   = in_range;
      ram_addr = wr_addr;
      ram_din  = wr_data;
    end
    ram_we = we_raw & rstn;
  end

  // Next-state logic for the clear sequencer, error flag and stall counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    val_nx   = val;
    err_nx   = err_addr;
    stall_nx = stall_cnt;

    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
          val_nx   = clr_val;
          err_nx   = 1'b0;
        end else if (accept && !in_range) begin
          err_nx = 1'b1;
        end
      end
      CLEAR: begin
        if (!disp_req) begin
          if (cnt == LAST_A) state_nx = DONE;
          else               cnt_nx   = cnt + AW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (wr_valid && !wr_ready && (stall_cnt != STALL_MAX))
      stall_nx = stall_cnt + STALL_W'(1);

    busy_nx = (state_nx == CLEAR) || (state_nx == DONE);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      val       <= 1'b0;
      err_addr  <= 1'b0;
      stall_cnt <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      val       <= val_nx;
      err_addr  <= err_nx;
      stall_cnt <= stall_nx;
      clr_busy  <= busy_nx;
      clr_done  <= done_nx;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized scoreboard bench for fb_write_arbiter against a behavioural model.
module tb_fb_write_arbiter;

  localparam int CELLS = 30000;
  localparam int SMAX  = 65535;

  logic        pclk = 1'b0;
  logic        rstn;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic        wr_valid;
  logic [14:0] wr_addr;
  logic        wr_data;
  logic        wr_ready;
  logic        clr_start;
  logic        clr_val;
  logic        clr_busy;
  logic        clr_done;
  logic        err_addr;
  logic [15:0] stall_cnt;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic        ram_din;

  fb_write_arbiter dut (
    .pclk(pclk), .rstn(rstn),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_val(clr_val), .clr_busy(clr_busy), .clr_done(clr_done),
    .err_addr(err_addr), .stall_cnt(stall_cnt),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int addr;
    int din;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  // Model state: what the screen-clear and write side should be doing now.
  bit  m_clr, m_done, m_val, m_err, m_acc, prev_wait;
  int  m_next, m_stall;
  int  prev_wa, prev_wd;
  int  clr_writes, done_pulses;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clr = 0; m_done = 0; m_val = 0; m_err = 0; m_acc = 0; prev_wait = 0;
    m_next = 0; m_stall = 0;
  endtask

  // Reference model: predicts outputs, pushes expected RAM writes, advances.
  always @(negedge pclk) begin
    int  e_en, e_we, e_addr, e_din;
    bit  e_rdy, din_known;
    if (!rstn) begin
      chk("rst_ram_we", int'(ram_we), 0);
      chk("rst_clr_busy", int'(clr_busy), 0);
      chk("rst_stall", int'(stall_cnt), 0);
      chk("rst_err", int'(err_addr), 0);
      if (disp_req) begin
        chk("rst_pass_en", int'(ram_en), 1);
        chk("rst_pass_addr", int'(ram_addr), int'(disp_addr));
      end
      model_reset();
    end else begin
      e_rdy = !m_clr && !m_done && !disp_req && !clr_start;
      din_known = 1;
      if (disp_req) begin
        e_en = 1; e_we = 0; e_addr = int'(disp_addr); e_din = 0;
      end else if (m_clr) begin
        e_en = 1; e_we = 1; e_addr = m_next; e_din = int'(m_val);
      end else if (wr_valid && e_rdy) begin
        e_en = 1; e_addr = int'(wr_addr); e_din = int'(wr_data);
        e_we = (int'(wr_addr) < CELLS) ? 1 : 0;
      end else begin
        e_en = 0; e_we = 0; e_addr = 0; e_din = 0; din_known = 0;
      end
      if (e_we == 1) exp_q.push_back('{addr: e_addr, din: e_din});

      chk("wr_ready", int'(wr_ready), int'(e_rdy));
      chk("ram_en", int'(ram_en), e_en);
      chk("ram_we", int'(ram_we), e_we);
      chk("ram_addr", int'(ram_addr), e_addr);
      if (din_known) chk("ram_din", int'(ram_din), e_din);
      chk("clr_busy", int'(clr_busy), int'(m_clr || m_done));
      chk("clr_done", int'(clr_done), int'(m_done));
      chk("err_addr", int'(err_addr), int'(m_err));
      chk("stall_cnt", int'(stall_cnt), m_stall);

      if (prev_wait) begin
        chk("req_hold_valid", int'(wr_valid), 1);
        chk("req_hold_addr", int'(wr_addr), prev_wa);
        chk("req_hold_data", int'(wr_data), prev_wd);
      end
      prev_wait = wr_valid && !e_rdy;
      prev_wa   = int'(wr_addr);
      prev_wd   = int'(wr_data);
      m_acc     = wr_valid && e_rdy;

      if (wr_valid && !e_rdy && m_stall < SMAX) m_stall++;
      if (m_done) begin
        m_done = 0;
      end else if (m_clr) begin
        if (!disp_req) begin
          if (m_next == CELLS - 1) begin m_clr = 0; m_done = 1; end
          else m_next++;
        end
      end else if (clr_start) begin
        m_clr = 1; m_next = 0; m_val = clr_val; m_err = 0;
      end else if (m_acc && int'(wr_addr) >= CELLS) begin
        m_err = 1;
      end
    end
  end

  // Monitor: every RAM write the DUT issues must match the next expected one.
  always @(negedge pclk) begin
    wr_t e;
    #1;
    if (rstn === 1'b1 && ram_we === 1'b1) begin
      if (clr_busy) clr_writes++;
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("mon_addr", int'(ram_addr), e.addr);
        chk("mon_din", int'(ram_din), e.din);
      end
    end
    if (rstn === 1'b1 && clr_done === 1'b1) done_pulses++;
  end

  task automatic step();
    @(posedge pclk);
    #2;
  endtask

  function automatic logic [14:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 15'(30000 + $urandom_range(0, 2767));
    if (r == 1) return 15'(CELLS - 1);
    return 15'($urandom_range(0, CELLS - 1));
  endfunction

  // Requester: retire an accepted request, optionally raise a new one.
  task automatic req_update();
    if (wr_valid && m_acc) wr_valid = 1'b0;
    if (!wr_valid && $urandom_range(0, 1) == 1) begin
      wr_valid = 1'b1;
      wr_addr  = rand_addr();
      wr_data  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    bit sent_second;
    int guard;
    model_reset();
    clr_writes = 0; done_pulses = 0;
    rstn = 1'b0; disp_req = 1'b1; disp_addr = 15'h0abc;
    wr_valid = 1'b0; wr_addr = '0; wr_data = 1'b0;
    clr_start = 1'b0; clr_val = 1'b0;
    repeat (3) step();
    rstn = 1'b1; disp_req = 1'b0;
    step();

    // Reset in the middle of a clear.
    clr_start = 1'b1; clr_val = 1'b1;
    step();
    clr_start = 1'b0;
    guard = 0;
    while (m_next != 1234 && guard < 3000) begin step(); guard++; end
    chk("reach_cnt_1234", m_next, 1234);
    chk("pre_rst_we", int'(ram_we), 1);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_busy", int'(clr_busy), 0);
    chk("async_rst_we", int'(ram_we), 0);
    model_reset();
    disp_req = 1'b1; disp_addr = 15'h2222;
    step(); step();
    rstn = 1'b1;
    step();
    disp_req = 1'b0;
    step();

    // Randomized traffic, no clears.
    repeat (2000) begin
      step();
      disp_req  = 1'($urandom_range(0, 1));
      disp_addr = 15'($urandom_range(0, 32767));
      req_update();
    end
    guard = 0;
    while (wr_valid && guard < 10) begin
      step(); disp_req = 1'b0;
      if (m_acc) wr_valid = 1'b0;
      guard++;
    end

    // Display blocks a pending write, then releases the port.
    step();
    disp_req = 1'b1; disp_addr = 15'h1234;
    wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 1'b1;
    repeat (3) step();
    disp_req = 1'b0;
    step();
    wr_valid = 1'b0;
    step();
    wr_valid = 1'b1; wr_addr = 15'd30000; wr_data = 1'b1;
    step();
    wr_valid = 1'b0;
    repeat (3) step();
    chk("err_sticky", int'(err_addr), 1);

    // Long stall, then a clear that collides with a pending write.
    wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 1'b0; disp_req = 1'b1;
    repeat (6000) step();
    clr_writes = 0; done_pulses = 0;
    disp_req = 1'b0; clr_start = 1'b1; clr_val = 1'b1;
    #1 chk("collide_wr_ready", int'(wr_ready), 0);
    step();
    clr_start = 1'b0;
    sent_second = 0;
    guard = 0;
    while ((m_clr || m_done) && guard < 80000) begin
      step();
      disp_req  = ~disp_req;
      clr_start = (!sent_second && m_next == 100) ? 1'b1 : 1'b0;
      if (clr_start) sent_second = 1;
      guard++;
    end
    clr_start = 1'b0;
    chk("clear_finished", int'(m_clr || m_done), 0);
    step();
    chk("clear_write_total", clr_writes, CELLS);
    chk("done_pulses", done_pulses, 1);
    chk("stall_saturated", int'(stall_cnt), SMAX);
    chk("err_cleared", int'(err_addr), 0);

    disp_req = 1'b0;
    guard = 0;
    while (wr_valid && guard < 10) begin
      step();
      if (m_acc) wr_valid = 1'b0;
      guard++;
    end
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
